// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Two byte requesters share one UART sender. A round-robin arbiter pushes
// accepted bytes into a small shared FIFO and a sequencer FSM hands them to
// the sender one frame at a time, using the synchronized sender idle flag.
module uart_tx_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int EN_CYCLES  = 2,
  parameter int TIMEOUT    = 8192
) (
  input  logic                        sysclk,
  input  logic                        reset,
  input  logic                        req0_valid,
  input  logic [7:0]                  req0_data,
  output logic                        req0_ready,
  input  logic                        req1_valid,
  input  logic [7:0]                  req1_data,
  output logic                        req1_ready,
  input  logic                        tx_status,
  output logic [7:0]                  tx_data,
  output logic                        tx_en,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        err_timeout,
  input  logic                        err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [15:0] EN_LAST = 16'(EN_CYCLES - 1);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EN,
    S_WAIT_START,
    S_WAIT_DONE
  } state_t;

  logic          sync1_q;
  logic          sync2_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic          lastGrant_q;
  state_t        state_q;
  logic [15:0]   cnt_q;
  logic          txEn_q;
  logic [7:0]    txData_q;
  logic          errTimeout_q;

  logic          full;
  logic          empty;
  logic          grant0;
  logic          grant1;
  logic          push;
  logic [7:0]    pushData;
  logic          pop;
  logic          timeoutHit;

  assign full  = (level_q == LEVEL_FULL);
  assign empty = (level_q == '0);

  // Two-flop synchronizer for the sender idle flag; idle (1) out of reset.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= tx_status;
      sync2_q <= sync1_q;
    end
  end

  // Round-robin grant: a lone requester always wins, a tie goes to the one
  // that was not granted last. Uses the registered full flag only.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!full) begin
      if (req0_valid && (!req1_valid || lastGrant_q)) begin
        grant0 = 1'b1;
      end else if (req1_valid && (!req0_valid || !lastGrant_q)) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign push       = grant0 | grant1;
  assign pushData   = grant0 ? req0_data : req1_data;

  assign pop = (state_q == S_IDLE) && !empty && sync2_q;

  assign timeoutHit = (state_q == S_WAIT_START) && sync2_q && (cnt_q == TO_LAST);

  // Occupancy update; a simultaneous push and pop leaves the level unchanged.
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO pointers, level and the arbiter's memory of the last winner.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      level_q     <= '0;
      lastGrant_q <= 1'b1;
    end else begin
      level_q <= level_d;
      if (push) begin
        wrPtr_q     <= wrPtr_q + AW'(1);
        lastGrant_q <= grant1;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + AW'(1);
      end
    end
  end

  // FIFO storage; contents only matter once written, so no reset needed.
  always_ff @(posedge sysclk) begin
    if (push) begin
      mem_q[wrPtr_q] <= pushData;
    end
  end

  // Sequencer: issue a frame, hold the strobe, wait for the sender to go
  // busy (bounded) and then idle again. Also owns the sticky timeout flag.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      txEn_q       <= 1'b0;
      txData_q     <= '0;
      errTimeout_q <= 1'b0;
    end else begin
      if (timeoutHit) begin
        errTimeout_q <= 1'b1;
      end else if (err_clr) begin
        errTimeout_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            txData_q <= mem_q[rdPtr_q];
            txEn_q   <= 1'b1;
            cnt_q    <= '0;
            state_q  <= S_EN;
          end
        end
        S_EN: begin
          if (cnt_q == EN_LAST) begin
            txEn_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_WAIT_START;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_WAIT_START: begin
          if (!sync2_q) begin
            state_q <= S_WAIT_DONE;
          end else if (cnt_q == TO_LAST) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_WAIT_DONE: begin
          if (sync2_q) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_en       = txEn_q;
  assign tx_data     = txData_q;
  assign err_timeout = errTimeout_q;
  assign fifo_level  = level_q;
  assign busy        = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Self-checking bench: a queue-based scoreboard of accepted bytes, a simple
// sender model driving tx_status, a table of arbitration vectors, directed
// corner-case sequences and a randomized traffic phase.
module tb_uart_tx_arbiter;

  localparam int DEPTH = 4;
  localparam int ENC   = 2;
  localparam int TOUT  = 8192;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       tx_status;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       busy;
  logic [2:0] fifo_level;
  logic       err_timeout;
  logic       err_clr;

  uart_tx_arbiter #(.FIFO_DEPTH(DEPTH), .EN_CYCLES(ENC), .TIMEOUT(TOUT)) dut (
    .sysclk(sysclk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tx_status(tx_status), .tx_data(tx_data), .tx_en(tx_en), .busy(busy),
    .fifo_level(fifo_level), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  // Free-running system clock.
  initial forever #5 sysclk = ~sysclk;

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       r0;
    logic       r1;
    int         level;
  } vec_t;

  int         compared = 0;
  int         mismatched = 0;
  logic [7:0] expQ[$];
  logic [7:0] accQ[$];
  int         modelLevel = 0;
  int         lastGrant = 1;
  bit         forceLow = 0;
  bit         forceHigh = 0;
  int         busyCnt = 0;
  int         senderBusy = 6;
  bit         prevTxEn = 0;
  bit         prevErr = 0;
  int         enLen = 0;
  logic [7:0] capData = 8'h00;
  int         sinceEnFall = 0;
  int         timeoutGap = -1;
  int         framesSeen = 0;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic driveStatus();
    if (forceLow) tx_status = 1'b0;
    else if (forceHigh) tx_status = 1'b1;
    else if (busyCnt > 0) begin
      tx_status = 1'b0;
      busyCnt--;
    end else tx_status = 1'b1;
  endtask

  // One sysclk cycle: apply inputs, check ready/level against the model,
  // then advance the scoreboard and sender model after the edge.
  task automatic applyStimulus(input logic v0, input logic [7:0] d0,
                               input logic v1, input logic [7:0] d1,
                               output logic r0, output logic r1,
                               output int lvl, output bit popped);
    bit   full;
    logic e0;
    logic e1;
    req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1;
    #1;
    full = (modelLevel == DEPTH);
    e0 = v0 && !full && (!v1 || lastGrant == 1);
    e1 = v1 && !full && (!v0 || lastGrant == 0);
    r0 = req0_ready;
    r1 = req1_ready;
    lvl = int'(fifo_level);
    check("req0_ready", int'(r0), int'(e0));
    check("req1_ready", int'(r1), int'(e1));
    check("fifo_level", lvl, modelLevel);
    @(posedge sysclk);
    if (e0) begin
      expQ.push_back(d0); accQ.push_back(d0); modelLevel++; lastGrant = 0;
    end else if (e1) begin
      expQ.push_back(d1); accQ.push_back(d1); modelLevel++; lastGrant = 1;
    end
    @(negedge sysclk);
    popped = 0;
    if (tx_en && !prevTxEn) begin
      popped = 1;
      framesSeen++;
      if (expQ.size() == 0) begin
        compared++; mismatched++;
        $display("[TB] FAIL unexpected_frame: got tx_data 0x%0h with nothing queued", tx_data);
      end else begin
        check("tx_data_order", int'(tx_data), int'(expQ.pop_front()));
        modelLevel--;
      end
      enLen = 1;
      capData = tx_data;
      busyCnt = senderBusy;
    end else if (tx_en) begin
      enLen++;
      check("tx_data_stable", int'(tx_data), int'(capData));
    end else if (prevTxEn) begin
      check("tx_en_length", enLen, ENC);
    end
    if (prevTxEn && !tx_en) sinceEnFall = 0;
    else sinceEnFall++;
    if (err_timeout && !prevErr) timeoutGap = sinceEnFall;
    prevTxEn = tx_en;
    prevErr = err_timeout;
    driveStatus();
  endtask

  task automatic idleCycles(input int n);
    logic r0, r1;
    int   lv;
    bit   p;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, r0, r1, lv, p);
  endtask

  task automatic clearModel();
    expQ.delete();
    modelLevel = 0; lastGrant = 1; prevTxEn = 0; prevErr = 0;
    enLen = 0; busyCnt = 0; sinceEnFall = 0;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_tx_en"}, int'(tx_en), 0);
    check({tag, "_fifo_level"}, int'(fifo_level), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic doReset();
    req0_valid = 0; req1_valid = 0; err_clr = 0;
    reset = 1'b0;
    clearModel();
    driveStatus();
    repeat (2) @(negedge sysclk);
    checkOutput("reset");
    check("reset_tx_data", int'(tx_data), 0);
    check("reset_err", int'(err_timeout), 0);
    check("reset_ready0", int'(req0_ready), 0);
    reset = 1'b1;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (n < bound && (expQ.size() != 0 || busy)) begin
      idleCycles(1);
      n++;
    end
    if (n >= bound) begin
      compared++; mismatched++;
      $display("[TB] FAIL drain_timeout: %0d bytes still queued, busy=%0d", expQ.size(), busy);
    end
  endtask

  initial begin
    vec_t       tbl[7];
    logic [7:0] tieExp[4];
    logic       r0, r1;
    int         lv, n, ia, ib, frames0;
    bit         p;

    tbl[0] = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b0, 0};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 8'h21, 1'b0, 1'b1, 1};
    tbl[2] = '{1'b1, 8'h12, 1'b1, 8'h22, 1'b1, 1'b0, 2};
    tbl[3] = '{1'b1, 8'h13, 1'b1, 8'h22, 1'b0, 1'b1, 3};
    tbl[4] = '{1'b1, 8'h13, 1'b1, 8'h23, 1'b0, 1'b0, 4};
    tbl[5] = '{1'b1, 8'h13, 1'b0, 8'h00, 1'b0, 1'b0, 4};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4};
    tieExp[0] = 8'hA0; tieExp[1] = 8'hB0; tieExp[2] = 8'hA1; tieExp[3] = 8'hB1;

    req0_data = 0; req1_data = 0; tx_status = 1;
    doReset();

    // T1: single byte, sender busy for 100 cycles.
    senderBusy = 100;
    applyStimulus(1'b1, 8'h55, 1'b0, 8'h00, r0, r1, lv, p);
    n = 0;
    while (busy && n < 400) begin idleCycles(1); n++; end
    check("t1_tx_data", int'(capData), 8'h55);
    check("t1_busy_span_ok", int'(n >= 100 && n <= 112), 1);
    check("t1_busy_end", int'(busy), 0);

    // T2: continuous tie between both requesters.
    doReset();
    senderBusy = 6;
    accQ.delete();
    ia = 0; ib = 0; n = 0;
    while (accQ.size() < 4 && n < 40) begin
      applyStimulus(1'b1, 8'(8'hA0 + ia), 1'b1, 8'(8'hB0 + ib), r0, r1, lv, p);
      if (r0) ia++;
      if (r1) ib++;
      n++;
    end
    for (int i = 0; i < 4; i++) check($sformatf("t2_accept_%0d", i), int'(accQ[i]), int'(tieExp[i]));
    drain(2000);

    // T3: table of arbitration vectors against a stalled sender, then release.
    doReset();
    forceLow = 1;
    idleCycles(4);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, r0, r1, lv, p);
      check($sformatf("tbl%0d_r0", i), int'(r0), int'(tbl[i].r0));
      check($sformatf("tbl%0d_r1", i), int'(r1), int'(tbl[i].r1));
      check($sformatf("tbl%0d_level", i), lv, tbl[i].level);
    end
    forceLow = 0;
    frames0 = framesSeen;
    n = 0;
    r0 = 0;
    while (!r0 && n < 200) begin
      applyStimulus(1'b1, 8'h13, 1'b0, 8'h00, r0, r1, lv, p);
      n++;
    end
    check("t3_held_until_pop", int'(framesSeen > frames0), 1);
    drain(3000);

    // T6: push and pop in the same cycle at level 1.
    forceLow = 1;
    idleCycles(4);
    applyStimulus(1'b1, 8'h61, 1'b0, 8'h00, r0, r1, lv, p);
    forceLow = 0;
    idleCycles(3);
    applyStimulus(1'b1, 8'h62, 1'b0, 8'h00, r0, r1, lv, p);
    check("t6_push_accepted", int'(r0), 1);
    check("t6_pop_same_cycle", int'(p), 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, r0, r1, lv, p);
    check("t6_level", lv, 1);
    drain(2000);

    // T4: start timeout with the sender stuck idle, then sticky clear.
    forceHigh = 1;
    timeoutGap = -1;
    applyStimulus(1'b1, 8'h41, 1'b0, 8'h00, r0, r1, lv, p);
    applyStimulus(1'b1, 8'h42, 1'b0, 8'h00, r0, r1, lv, p);
    n = 0;
    while (timeoutGap < 0 && n < TOUT + 200) begin idleCycles(1); n++; end
    forceHigh = 0;
    check("t4_timeout_gap", timeoutGap, TOUT);
    drain(2000);
    check("t4_err_sticky", int'(err_timeout), 1);
    err_clr = 1;
    idleCycles(1);
    err_clr = 0;
    check("t4_err_cleared", int'(err_timeout), 0);

    // T5: reset while a frame is in progress with three bytes queued.
    senderBusy = 100;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h81 + i), 1'b0, 8'h00, r0, r1, lv, p);
    idleCycles(10);
    check("t5_queued", int'(fifo_level), 3);
    #2 reset = 1'b0;
    #1 checkOutput("t5_midreset");
    clearModel();
    driveStatus();
    @(negedge sysclk);
    reset = 1'b1;
    frames0 = framesSeen;
    idleCycles(150);
    check("t5_no_frames", framesSeen - frames0, 0);

    // Randomized traffic against the scoreboard.
    doReset();
    for (int i = 0; i < 800; i++) begin
      senderBusy = int'($urandom_range(4, 12));
      applyStimulus(1'($urandom_range(0, 99) < 55), 8'($urandom),
                    1'($urandom_range(0, 99) < 45), 8'($urandom), r0, r1, lv, p);
    end
    drain(4000);
    check("final_busy", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
